// File: rtl/gcd_stein_ci_if.sv
// gcd_stein_ci_if
//   Bundles the command/result signals of the Stein GCD engine.
//   master : drives start, mode and operands; observes result, done, busy.
//   slave  : the engine side (gcd_stein_ci).
//   Signals:
//     avs_start         start pulse (qualified by clk_en inside the engine)
//     avs_n             mode: 0/3 = GCD, 1 = coprime test, 2 = step count
//     avs_s0_writedata  operand A
//     avs_s1_writedata  operand B
//     avs_s2_readdata   registered result
//     avs_done          one-cycle completion pulse
//     avs_busy          operation in progress
interface gcd_stein_ci_if #(
    parameter int WIDTH = 32
);
    logic             avs_start;
    logic [1:0]       avs_n;
    logic [WIDTH-1:0] avs_s0_writedata;
    logic [WIDTH-1:0] avs_s1_writedata;
    logic [WIDTH-1:0] avs_s2_readdata;
    logic             avs_done;
    logic             avs_busy;

    modport master (
        output avs_start, avs_n, avs_s0_writedata, avs_s1_writedata,
        input  avs_s2_readdata, avs_done, avs_busy
    );

    modport slave (
        input  avs_start, avs_n, avs_s0_writedata, avs_s1_writedata,
        output avs_s2_readdata, avs_done, avs_busy
    );
endinterface

// File: rtl/gcd_stein_ci.sv
// gcd_stein_ci
//   Binary (Stein) GCD engine with clock enable.
//   IDLE latches operands and mode on a qualified start; STRIP removes common
//   factors of two (counted in k); REDUCE removes remaining factors of two and
//   subtracts the smaller operand from the larger until both are equal, after
//   which the GCD is the common value shifted left by k.
//   Ports:
//     csi_clk      clock
//     rsi_reset_n  asynchronous active-low reset
//     clk_en       clock enable; all algorithm state freezes while low
//     avs          command/result bundle (gcd_stein_ci_if.slave)
module gcd_stein_ci #(
    parameter int WIDTH = 32,
    parameter int STEPW = $clog2(5*WIDTH)+1
) (
    input  logic          csi_clk,
    input  logic          rsi_reset_n,
    input  logic          clk_en,
    gcd_stein_ci_if.slave avs
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STRIP  = 2'd1,
        S_REDUCE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [STEPW-1:0] step_q, step_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [STEPW-1:0] step_inc;
    logic             term;
    logic [WIDTH-1:0] g;

    // Step counter saturates rather than wrapping.
    assign step_inc = (&step_q) ? step_q : step_q + 1'b1;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        step_d   = step_q;
        mode_d   = mode_q;
        result_d = result_q;
        done_d   = 1'b0;      // pulse clears on the next edge regardless of clk_en
        term     = 1'b0;
        g        = '0;

        if (clk_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (avs.avs_start) begin
                        a_d     = avs.avs_s0_writedata;
                        b_d     = avs.avs_s1_writedata;
                        mode_d  = avs.avs_n;
                        k_d     = '0;
                        step_d  = '0;
                        state_d = S_STRIP;
                    end
                end

                S_STRIP: begin
                    step_d = step_inc;
                    if (a_q == '0 || b_q == '0) begin
                        term = 1'b1;
                        g    = a_q | b_q;
                    end else if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + 1'b1;
                    end else begin
                        state_d = S_REDUCE;
                    end
                end

                S_REDUCE: begin
                    step_d = step_inc;
                    if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_q == b_q) begin
                        term = 1'b1;
                        g    = a_q << k_q;
                    end else if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end

                default: state_d = S_IDLE;
            endcase

            if (term) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                unique case (mode_q)
                    2'd1:    result_d = {{(WIDTH-1){1'b0}}, (g == WIDTH'(1))};
                    2'd2:    result_d = {{(WIDTH-STEPW){1'b0}}, step_inc};
                    default: result_d = g;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            step_q   <= '0;
            mode_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            step_q   <= step_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign avs.avs_s2_readdata = result_q;
    assign avs.avs_done        = done_q;
    assign avs.avs_busy        = (state_q != S_IDLE);

endmodule
